// File: rtl/tube_scan_ctrl.sv
// Multiplexed seven-segment scan controller for the dual-bus tube display.
// Hex or decimal (iterative double-dabble) content, zero blanking, dp and blink.
module tube_scan_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int BIN_W      = 16,
  parameter int SCAN_DIV   = 100000,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                    clk_100,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    mode_dec,
  input  logic                    lz_blank,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic                    busy,
  output logic [NUM_DIGITS-1:0]   tube_scan,
  output logic [7:0]              tube_signal_left,
  output logic [7:0]              tube_signal_right
);

  localparam int H      = NUM_DIGITS / 2;
  localparam int NW     = 4 * NUM_DIGITS;
  // Three spare BCD digits hold any BIN_W-bit value, so overflow is visible.
  localparam int BCD_W  = 4 * (NUM_DIGITS + 3);
  localparam int IDX_W  = (H > 1) ? $clog2(H) : 1;
  localparam int SC_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BL_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int CNT_W  = $clog2(BIN_W + 1);

  typedef enum logic {S_IDLE, S_CONV} conv_state_e;

  conv_state_e state_q, state_d;

  logic [NW-1:0]         disp_q;
  logic                  ovf_q;
  logic                  lz_q;
  logic [NUM_DIGITS-1:0] dp_q;
  logic [NUM_DIGITS-1:0] blink_mask_q;

  logic [BIN_W-1:0]      bin_q;
  logic [BCD_W-1:0]      bcd_q, bcd_adj, bcd_d;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  load_ok, last_bit, ovf_d;

  logic [SC_W-1:0]       scan_cnt;
  logic [IDX_W-1:0]      idx_q;
  logic [BL_W-1:0]       blink_cnt;
  logic                  blink_q;

  logic [NUM_DIGITS-1:0] lz_off;
  logic [7:0]            seg [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] scan_d;
  logic [7:0]            left_d, right_d;
  logic                  seen_nz;

  function automatic logic [7:0] font(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'h0: s = 8'hFC;  4'h1: s = 8'h60;  4'h2: s = 8'hDA;  4'h3: s = 8'hF2;
      4'h4: s = 8'h66;  4'h5: s = 8'hB6;  4'h6: s = 8'hBE;  4'h7: s = 8'hE0;
      4'h8: s = 8'hFE;  4'h9: s = 8'hF6;  4'hA: s = 8'hEE;  4'hB: s = 8'h3E;
      4'hC: s = 8'h9C;  4'hD: s = 8'h7A;  4'hE: s = 8'h9E;  default: s = 8'h8E;
    endcase
    return s;
  endfunction

  // valid/ready: a load is taken on any edge where load=1 and busy=0;
  // a load seen while busy=1 is discarded with no side effects.
  assign load_ok  = load && (state_q == S_IDLE);
  assign last_bit = (state_q == S_CONV) && (bit_cnt == CNT_W'(BIN_W - 1));
  assign busy     = (state_q == S_CONV);

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (load_ok && mode_dec) state_d = S_CONV;
      S_CONV:  if (last_bit)            state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // One double-dabble step: add 3 to every digit >= 5, then shift in the next bit.
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      else                         bcd_adj[4*i +: 4] = bcd_q[4*i +: 4];
    end
    bcd_d = {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
    ovf_d = |bcd_d[BCD_W-1:NW];
  end

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      disp_q       <= '0;
      ovf_q        <= 1'b0;
      lz_q         <= 1'b0;
      dp_q         <= '0;
      blink_mask_q <= '0;
      bin_q        <= '0;
      bcd_q        <= '0;
      bit_cnt      <= '0;
    end else begin
      if (load_ok) begin
        lz_q         <= lz_blank;
        dp_q         <= dp_mask;
        blink_mask_q <= blink_mask;
        if (mode_dec) begin
          bin_q   <= value[BIN_W-1:0];
          bcd_q   <= '0;
          bit_cnt <= '0;
        end else begin
          disp_q <= value;
          ovf_q  <= 1'b0;
        end
      end
      if (state_q == S_CONV) begin
        bcd_q   <= bcd_d;
        bin_q   <= bin_q << 1;
        bit_cnt <= bit_cnt + CNT_W'(1);
        if (last_bit) begin
          disp_q <= bcd_d[NW-1:0];
          ovf_q  <= ovf_d;
        end
      end
    end
  end

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt  <= '0;
      idx_q     <= '0;
      blink_cnt <= '0;
      blink_q   <= 1'b0;
    end else begin
      if (scan_cnt == SC_W'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        if (idx_q == IDX_W'(H - 1)) idx_q <= '0;
        else                        idx_q <= idx_q + IDX_W'(1);
      end else begin
        scan_cnt <= scan_cnt + SC_W'(1);
      end
      if (blink_cnt == BL_W'(BLINK_DIV - 1)) begin
        blink_cnt <= '0;
        blink_q   <= ~blink_q;
      end else begin
        blink_cnt <= blink_cnt + BL_W'(1);
      end
    end
  end

  // Digit i is a leading zero when it and every digit above it are zero.
  always_comb begin
    seen_nz = 1'b0;
    lz_off  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      seen_nz   = seen_nz | (disp_q[4*i +: 4] != 4'h0);
      lz_off[i] = lz_q & ~seen_nz & (i != 0);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      logic [7:0] glyph;
      if (ovf_q)          glyph = 8'h02;
      else if (lz_off[i]) glyph = 8'h00;
      else                glyph = font(disp_q[4*i +: 4]);
      if (blink_q && blink_mask_q[i]) seg[i] = 8'h00;
      else                            seg[i] = glyph | {7'b0, dp_q[i]};
    end
  end

  always_comb begin
    scan_d  = '0;
    left_d  = 8'h00;
    right_d = 8'h00;
    for (int i = 0; i < H; i++) begin
      if (idx_q == IDX_W'(i)) begin
        scan_d[i]     = 1'b1;
        scan_d[i + H] = 1'b1;
        right_d       = seg[i];
        left_d        = seg[i + H];
      end
    end
  end

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      tube_scan         <= '0;
      tube_signal_left  <= 8'h00;
      tube_signal_right <= 8'h00;
    end else begin
      tube_scan         <= scan_d;
      tube_signal_left  <= left_d;
      tube_signal_right <= right_d;
    end
  end

endmodule

// File: tb/tb_tube_scan_ctrl.sv
// Directed bench for tube_scan_ctrl: an 8-digit instance for hex/decimal/blink/reset
// and a 4-digit instance for the decimal overflow boundary.
module tb_tube_scan_ctrl;

  logic        clk_100 = 1'b0;
  logic        rst_n   = 1'b0;

  logic        load = 1'b0, mode_dec = 1'b0, lz_blank = 1'b0;
  logic [31:0] value = '0;
  logic [7:0]  dp_mask = '0, blink_mask = '0;
  logic        busy;
  logic [7:0]  tube_scan, left, right;

  logic        load2 = 1'b0, mode_dec2 = 1'b0, lz_blank2 = 1'b0;
  logic [15:0] value2 = '0;
  logic [3:0]  dp_mask2 = '0, blink_mask2 = '0;
  logic        busy2;
  logic [3:0]  tube_scan2;
  logic [7:0]  left2, right2;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;

  always #5 clk_100 = ~clk_100;

  always @(posedge clk_100 or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  tube_scan_ctrl #(.NUM_DIGITS(8), .BIN_W(16), .SCAN_DIV(4), .BLINK_DIV(64)) dut (
    .clk_100(clk_100), .rst_n(rst_n), .load(load), .value(value),
    .mode_dec(mode_dec), .lz_blank(lz_blank), .dp_mask(dp_mask),
    .blink_mask(blink_mask), .busy(busy), .tube_scan(tube_scan),
    .tube_signal_left(left), .tube_signal_right(right)
  );

  tube_scan_ctrl #(.NUM_DIGITS(4), .BIN_W(16), .SCAN_DIV(4), .BLINK_DIV(64)) dut2 (
    .clk_100(clk_100), .rst_n(rst_n), .load(load2), .value(value2),
    .mode_dec(mode_dec2), .lz_blank(lz_blank2), .dp_mask(dp_mask2),
    .blink_mask(blink_mask2), .busy(busy2), .tube_scan(tube_scan2),
    .tube_signal_left(left2), .tube_signal_right(right2)
  );

  task automatic tick();
    @(posedge clk_100);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [31:0] v, input logic md, input logic lz,
                         input logic [7:0] dp, input logic [7:0] bl);
    value = v; mode_dec = md; lz_blank = lz; dp_mask = dp; blink_mask = bl;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic do_load2(input logic [15:0] v);
    value2 = v; mode_dec2 = 1'b1; lz_blank2 = 1'b0; dp_mask2 = '0; blink_mask2 = '0;
    load2 = 1'b1;
    tick();
    load2 = 1'b0;
  endtask

  task automatic wait_scan(input string tag, input logic [7:0] pat);
    int n = 0;
    while (tube_scan !== pat && n < 40) begin tick(); n++; end
    check({tag, "_reach"}, 32'(tube_scan), 32'(pat));
  endtask

  task automatic wait_scan2(input string tag, input logic [3:0] pat);
    int n = 0;
    while (tube_scan2 !== pat && n < 40) begin tick(); n++; end
    check({tag, "_reach"}, 32'(tube_scan2), 32'(pat));
  endtask

  task automatic wait_idle2(input string tag);
    int n = 0;
    while (busy2 === 1'b1 && n < 40) begin tick(); n++; end
    check({tag, "_idle"}, 32'(busy2), 32'd0);
  endtask

  initial begin
    int cnt;
    int hits;

    // reset state
    repeat (3) @(posedge clk_100);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_scan", 32'(tube_scan), 0);
    check("rst_left", 32'(left), 0);
    check("rst_right", 32'(right), 0);
    rst_n = 1'b1;
    tick();
    check("first_scan", 32'(tube_scan), 32'h11);

    // hex DEADBEEF: digits 7..0 = D E A D B E E F
    do_load(32'hDEADBEEF, 1'b0, 1'b0, 8'h00, 8'h00);
    check("hex_busy", 32'(busy), 0);
    tick();
    check("hex_busy2", 32'(busy), 0);
    wait_scan("hex_i0", 8'h11);
    check("hex_i0_left", 32'(left), 32'h7A);
    check("hex_i0_right", 32'(right), 32'h8E);
    wait_scan("hex_i1", 8'h22);
    check("hex_i1_left", 32'(left), 32'hEE);
    check("hex_i1_right", 32'(right), 32'h9E);
    wait_scan("hex_i3", 8'h88);
    check("hex_i3_left", 32'(left), 32'h7A);
    check("hex_i3_right", 32'(right), 32'h3E);

    // hex with leading-zero blanking: 0x000000A0
    do_load(32'h000000A0, 1'b0, 1'b1, 8'h00, 8'h00);
    tick();
    wait_scan("hlz_i0", 8'h11);
    check("hlz_i0_left", 32'(left), 32'h00);
    check("hlz_i0_right", 32'(right), 32'hFC);
    wait_scan("hlz_i1", 8'h22);
    check("hlz_i1_right", 32'(right), 32'hEE);
    check("hlz_i1_left", 32'(left), 32'h00);

    // decimal 1234 with blanking
    do_load(32'd1234, 1'b1, 1'b1, 8'h00, 8'h00);
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin cnt++; tick(); end
    check("dec_busy_len", 32'(cnt), 16);
    tick();
    wait_scan("dec_i0", 8'h11);
    check("dec_i0_right", 32'(right), 32'h66);
    check("dec_i0_left", 32'(left), 32'h00);
    wait_scan("dec_i1", 8'h22);
    check("dec_i1_right", 32'(right), 32'hF2);
    wait_scan("dec_i3", 8'h88);
    check("dec_i3_right", 32'(right), 32'h60);
    check("dec_i3_left", 32'(left), 32'h00);

    // load while busy is dropped, masks included
    do_load(32'd1234, 1'b1, 1'b1, 8'h00, 8'h00);
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      cnt++;
      if (cnt == 5) begin
        value = 32'd42; lz_blank = 1'b0; dp_mask = 8'hFF; load = 1'b1;
      end else begin
        load = 1'b0;
      end
      tick();
    end
    load = 1'b0;
    check("lwb_busy_len", 32'(cnt), 16);
    tick();
    wait_scan("lwb_i0", 8'h11);
    check("lwb_i0_right", 32'(right), 32'h66);
    check("lwb_i0_left", 32'(left), 32'h00);
    wait_scan("lwb_i2", 8'h44);
    check("lwb_i2_right", 32'(right), 32'hDA);

    // 4-digit instance: 9999 fits, 10000 and 65535 overflow
    do_load2(16'd9999);
    wait_idle2("d2_9999");
    tick();
    wait_scan2("d2_9999_i0", 4'h5);
    check("d2_9999_left", 32'(left2), 32'hF6);
    check("d2_9999_right", 32'(right2), 32'hF6);
    do_load2(16'd10000);
    wait_idle2("d2_10000");
    tick();
    wait_scan2("d2_10000_i0", 4'h5);
    check("d2_10000_left", 32'(left2), 32'h02);
    check("d2_10000_right", 32'(right2), 32'h02);
    do_load2(16'd65535);
    wait_idle2("d2_65535");
    tick();
    wait_scan2("d2_ovf_i0", 4'h5);
    check("d2_ovf_i0_left", 32'(left2), 32'h02);
    check("d2_ovf_i0_right", 32'(right2), 32'h02);
    wait_scan2("d2_ovf_i1", 4'hA);
    check("d2_ovf_i1_left", 32'(left2), 32'h02);
    check("d2_ovf_i1_right", 32'(right2), 32'h02);

    // blink digit1, dp on digit0; phase derived from cycles since reset release
    do_load(32'h0, 1'b0, 1'b0, 8'h01, 8'h02);
    tick();
    hits = 0;
    for (int k = 0; k < 160; k++) begin
      if (tube_scan === 8'h11) check("dp_d0", 32'(right), 32'hFD);
      if (tube_scan === 8'h22) begin
        hits++;
        check("blink_d1", 32'(right), (((cyc - 1) / 64) % 2 == 1) ? 32'h00 : 32'hFC);
        check("blink_d5", 32'(left), 32'hFC);
      end
      tick();
    end
    check("blink_hits", 32'(hits), 40);

    // asynchronous reset during a conversion
    do_load(32'd1234, 1'b1, 1'b1, 8'h00, 8'h00);
    repeat (4) tick();
    check("pre_rst_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_scan", 32'(tube_scan), 0);
    check("arst_left", 32'(left), 0);
    check("arst_right", 32'(right), 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_scan", 32'(tube_scan), 32'h11);
    check("post_rst_left", 32'(left), 32'hFC);
    check("post_rst_right", 32'(right), 32'hFC);
    check("post_rst_busy", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
